lcd_timing_gen: RTL

Generates raster timing for the Tang Nano 9K 800x480 RGB LCD. Outputs the active-area pixel and line coordinates consumed by the colour generator, which maps PixelCount/LineCount to LCD_R/G/B. Also drives LCD_DE, LCD_HSYNC and LCD_VSYNC, plus line/frame strobes and a frame counter for animation logic. Sits between the PLL-derived pixel clock and the colour/pixel path.

---
 rtl/lcd_timing_gen.sv | 94 +++++++++
 1 files changed

// File: rtl/lcd_timing_gen.sv
// Raster timing generator for an 800x480 RGB LCD panel.
// Produces DE/HSYNC/VSYNC, active-area coordinates, strobes and a frame count.
module lcd_timing_gen #(
   parameter int H_ACTIVE  = 800,
   parameter int H_FP      = 210,
   parameter int H_SYNC    = 1,
   parameter int H_BP      = 182,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 45,
   parameter int V_SYNC    = 5,
   parameter int V_BP      = 0,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0
) (
   input  logic        PixelClk,
   input  logic        nRST,
   input  logic        En,
   output logic [15:0] PixelCount,
   output logic [15:0] LineCount,
   output logic        LCD_DE,
   output logic        LCD_HSYNC,
   output logic        LCD_VSYNC,
   output logic        LineStart,
   output logic        FrameStart,
   output logic [15:0] FrameCount
);

   localparam logic [15:0] HT_LAST = 16'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
   localparam logic [15:0] VT_LAST = 16'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
   localparam logic [15:0] HA_LO   = 16'(H_SYNC + H_BP);
   localparam logic [15:0] HA_HI   = 16'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [15:0] VA_LO   = 16'(V_SYNC + V_BP);
   localparam logic [15:0] VA_HI   = 16'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [15:0] HS_END  = 16'(H_SYNC);
   localparam logic [15:0] VS_END  = 16'(V_SYNC);

   logic [15:0] h;
   logic [15:0] v;
   logic        started;
   logic        h_act;
   logic        v_act;
   logic        h_zero;
   logic        v_zero;

   always_comb begin
      h_act  = (h >= HA_LO) && (h < HA_HI);
      v_act  = (v >= VA_LO) && (v < VA_HI);
      h_zero = (h == 16'd0);
      v_zero = (v == 16'd0);
   end

   // Outputs are a one-cycle-delayed image of (h,v); position advances after.
   always_ff @(posedge PixelClk) begin
      if (!nRST) begin
         h          <= 16'd0;
         v          <= 16'd0;
         started    <= 1'b0;
         PixelCount <= 16'd0;
         LineCount  <= 16'd0;
         LCD_DE     <= 1'b0;
         LCD_HSYNC  <= ~HSYNC_POL;
         LCD_VSYNC  <= ~VSYNC_POL;
         LineStart  <= 1'b0;
         FrameStart <= 1'b0;
         FrameCount <= 16'd0;
      end else if (En) begin
         PixelCount <= h_act ? (h - HA_LO) : 16'd0;
         LineCount  <= v_act ? (v - VA_LO) : 16'd0;
         LCD_DE     <= h_act && v_act;
         LCD_HSYNC  <= (h < HS_END) ? HSYNC_POL : ~HSYNC_POL;
         LCD_VSYNC  <= (v < VS_END) ? VSYNC_POL : ~VSYNC_POL;
         LineStart  <= h_zero;
         FrameStart <= h_zero && v_zero;
         // The first frame start after reset opens frame 0; later ones close a frame.
         if (h_zero && v_zero) begin
            started <= 1'b1;
            if (started) begin
               FrameCount <= FrameCount + 16'd1;
            end
         end
         if (h == HT_LAST) begin
            h <= 16'd0;
            v <= (v == VT_LAST) ? 16'd0 : v + 16'd1;
         end else begin
            h <= h + 16'd1;
         end
      end else begin
         LCD_DE     <= 1'b0;
         LineStart  <= 1'b0;
         FrameStart <= 1'b0;
      end
   end

endmodule
